// File: rtl/io_pkg.sv
// Shared IO-map constants for the switch debouncer and the core IO block.
// SW_W is the 32-bit IO width also used by the core's IO map.
package io_pkg;

   localparam int SW_W            = 32;
   localparam int DB_CYCLES_DEF   = 500000;
   localparam int SYNC_STAGES_DEF = 2;

   typedef logic [SW_W-1:0] sw_vec_t;

   // Counter width able to hold 0..cycles; never narrower than one bit.
   function automatic int cnt_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch bit: SYNC_STAGES-flop synchroniser, then a stability counter that
// accepts a new level after DB_CYCLES consecutive differing cycles; no backpressure.
module sw_db_bit
   import io_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_stable
);

   localparam int            CW       = cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   synced;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
   assign synced = sync_q[SYNC_STAGES-1];

   // Any return to the stable level throws away the partial count.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (synced == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = synced;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign o_stable = stable_q;

endmodule

// File: rtl/sw_debouncer.sv
// 32-bit switch debouncer: o_io_sw follows a held raw change after SYNC_STAGES+DB_CYCLES
// cycles, no backpressure; change pulse and sticky W1C mask only with SW_CHG_TRACK_EN.
module sw_debouncer
   import io_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [SW_W-1:0] i_sw_raw,
   output logic [SW_W-1:0] o_io_sw,
   output logic            o_sw_change,
   output logic [SW_W-1:0] o_sw_chg_mask,
   input  logic [SW_W-1:0] i_chg_clr
);

   sw_vec_t stable;
   sw_vec_t io_sw_q, io_sw_d;

   for (genvar g = 0; g < SW_W; g++) begin : g_bit
      sw_db_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_bit (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_raw    (i_sw_raw[g]),
         .o_stable (stable[g])
      );
   end

   // Registering the stable vector lets the change pulse line up with o_io_sw.
   assign io_sw_d = stable;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         io_sw_q <= '0;
      end else begin
         io_sw_q <= io_sw_d;
      end
   end

   assign o_io_sw = io_sw_q;

`ifdef SW_CHG_TRACK_EN
   sw_vec_t chg_bits;
   logic    change_q, change_d;
   sw_vec_t mask_q, mask_d;

   // A new change on a bit overrides a clear strobe hitting it in the same cycle.
   always_comb begin
      chg_bits = io_sw_d ^ io_sw_q;
      change_d = |chg_bits;
      mask_d   = (mask_q & ~i_chg_clr) | chg_bits;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         change_q <= 1'b0;
         mask_q   <= '0;
      end else begin
         change_q <= change_d;
         mask_q   <= mask_d;
      end
   end

   assign o_sw_change   = change_q;
   assign o_sw_chg_mask = mask_q;
`else
   logic chg_clr_unused;

   assign chg_clr_unused = |i_chg_clr;
   assign o_sw_change    = 1'b0;
   assign o_sw_chg_mask  = '0;
`endif

endmodule

// File: doc/sw_debouncer.md
SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops per switch bit; legal range is 2 or more.
REQ-002 Parameter DB_CYCLES, default 500000: number of consecutive stable i_clk cycles required to accept a new level (10 ms at 50 MHz); legal range is 1 or more.
REQ-003 Port i_clk, input, 1: the single clock; all state is on the rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_sw_raw, input, 32: raw, asynchronous board switch levels.
REQ-006 Port o_io_sw, output, 32: debounced switch levels; drives the core's i_io_sw.
REQ-007 Port o_sw_change, output, 1: one-cycle pulse in any cycle in which at least one o_io_sw bit changes.
REQ-008 Port o_sw_chg_mask, output, 32: sticky per-bit change flags.
REQ-009 Port i_chg_clr, input, 32: write-1-to-clear strobe for o_sw_chg_mask, one cycle per write.

Function
REQ-010 Each bit SHALL pass through SYNC_STAGES flops; the last stage is "synced".
REQ-011 Each bit SHALL keep a counter of width clog2(DB_CYCLES+1); the counter clears whenever synced equals the stable level.
REQ-012 While synced differs from stable, the counter SHALL increment every cycle; on the cycle the counter equals DB_CYCLES-1, stable takes the synced value and the counter clears.
REQ-013 Latency: a raw change held steady SHALL appear on o_io_sw exactly SYNC_STAGES+DB_CYCLES cycles after the first sampling edge.
REQ-014 A synced pulse or glitch shorter than DB_CYCLES cycles SHALL leave o_io_sw unchanged and reset that bit's count.
REQ-015 Bits are independent; bits that qualify in the same cycle SHALL update in that same cycle and produce a single o_sw_change pulse.
REQ-016 o_sw_change SHALL be registered and asserted for exactly the cycle in which o_io_sw shows the new value.
REQ-017 o_sw_chg_mask[i] SHALL set in the cycle o_io_sw[i] changes, in either direction.
REQ-018 o_sw_chg_mask[i] SHALL clear on the edge after i_chg_clr[i]=1.
REQ-019 If set and clear occur on the same bit in the same cycle, set SHALL win.
REQ-020 No counter SHALL ever exceed DB_CYCLES-1; the counters do not wrap.

Reset
REQ-021 While i_rst_n=0, all synchroniser flops, counters, o_io_sw, o_sw_change and o_sw_chg_mask SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, a held nonzero input qualifies per REQ-013 and sets its change flags.

Configuration
REQ-023 With macro SW_CHG_TRACK_EN defined, REQ-007, REQ-008, REQ-009 and REQ-016 through REQ-019 SHALL be implemented.
REQ-024 Without SW_CHG_TRACK_EN, o_sw_change and o_sw_chg_mask SHALL be tied to 0, i_chg_clr SHALL be ignored, and no tracking flops SHALL be inferred; o_io_sw behaviour is identical in both builds.

Structure
REQ-025 Package io_pkg SHALL hold SW_W=32, DB_CYCLES_DEF=500000 and SYNC_STAGES_DEF=2; the 32-bit IO width is shared with the core's IO map.
REQ-026 The per-bit synchroniser, counter and stable register SHALL live in sub-module sw_db_bit, instantiated SW_W times via generate.
REQ-027 The change detection and sticky mask logic SHALL live in the top-level module.

Verification (all scenarios run with SYNC_STAGES=2, DB_CYCLES=4)
REQ-028 Reset with i_sw_raw=0 -> o_io_sw=0, o_sw_chg_mask=0 and o_sw_change=0 for 20 cycles.
REQ-029 i_sw_raw[0] 0->1 at cycle 0 and held -> o_io_sw[0]=1 at exactly cycle 6, o_sw_change=1 only at cycle 6, o_sw_chg_mask=0x00000001.
REQ-030 i_sw_raw[3] high for 3 cycles, then low -> o_io_sw[3] stays 0 and o_sw_change is never asserted.
REQ-031 With o_sw_chg_mask=0x1, i_chg_clr=0x1 for one cycle -> mask=0 on the next cycle; the same strobe coinciding with a new bit-0 change -> mask stays 0x1.
REQ-032 i_sw_raw 0->0xFFFFFFFF at cycle 0 -> o_io_sw=0xFFFFFFFF at cycle 6 in one step, a single o_sw_change pulse, mask=0xFFFFFFFF.
REQ-033 i_sw_raw[5] high; i_rst_n pulsed low for 1 cycle at cycle 4 -> outputs are 0 immediately, and o_io_sw[5]=1 exactly 6 cycles after reset release.
